multicycle_cpu: RTL

//  Parametrised multi-cycle successor to the single-cycle RV32 core: one FSM sequences

---
 rtl/multicycle_cpu_pkg.sv | 105 ++++++++++
 rtl/mc_regfile.sv | 47 ++++
 rtl/multicycle_cpu.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_cpu_pkg.sv
// Shared types and encodings for the multi-cycle RV32-subset core.
// The optional BEQ/BNE support is enabled by defining MULTICYCLE_CPU_BRANCH_EN.
package multicycle_cpu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    WB,
    HALT
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_SLT
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL     = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  // Per-instruction control derived from opcode/funct fields only
  typedef struct packed {
    logic    legal;
    logic    use_imm;
    logic    wen;
    logic    branch;
    alu_op_e op;
  } dec_t;

  function automatic dec_t decode_op(input logic [6:0] opcode,
                                     input logic [2:0] f3,
                                     input logic [6:0] f7);
    dec_t d;
    d.legal   = 1'b0;
    d.use_imm = 1'b0;
    d.wen     = 1'b0;
    d.branch  = 1'b0;
    d.op      = ALU_ADD;
    case (opcode)
      OPC_OP: begin
        d.wen = 1'b1;
        if (f7 == F7_BASE) begin
          d.legal = 1'b1;
          case (f3)
            F3_ADD_SUB: d.op = ALU_ADD;
            F3_SLL:     d.op = ALU_SLL;
            F3_SLT:     d.op = ALU_SLT;
            F3_XOR:     d.op = ALU_XOR;
            F3_SRL:     d.op = ALU_SRL;
            F3_OR:      d.op = ALU_OR;
            F3_AND:     d.op = ALU_AND;
            default:    d.legal = 1'b0;
          endcase
        end else if (f7 == F7_SUB && f3 == F3_ADD_SUB) begin
          d.legal = 1'b1;
          d.op    = ALU_SUB;
        end
      end
      OPC_OP_IMM: begin
        d.wen     = 1'b1;
        d.use_imm = 1'b1;
        d.legal   = 1'b1;
        case (f3)
          F3_ADD_SUB: d.op = ALU_ADD;
          F3_SLT:     d.op = ALU_SLT;
          F3_XOR:     d.op = ALU_XOR;
          F3_OR:      d.op = ALU_OR;
          F3_AND:     d.op = ALU_AND;
          default:    d.legal = 1'b0;
        endcase
      end
`ifdef MULTICYCLE_CPU_BRANCH_EN
      OPC_BRANCH: begin
        d.branch = 1'b1;
        d.op     = ALU_SUB;
        d.legal  = (f3 == F3_BEQ) || (f3 == F3_BNE);
      end
`endif
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mc_regfile.sv
// Register file: NREG x XLEN, two operand read ports plus a debug read port
// (all combinational), one synchronous write port, x0 hard-wired to zero.
module mc_regfile #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [$clog2(NREG)-1:0] raddr1,
  input  logic [$clog2(NREG)-1:0] raddr2,
  output logic [XLEN-1:0]         rdata1,
  output logic [XLEN-1:0]         rdata2,
  input  logic [$clog2(NREG)-1:0] dbg_addr,
  output logic [XLEN-1:0]         dbg_data,
  input  logic                    we,
  input  logic [$clog2(NREG)-1:0] waddr,
  input  logic [XLEN-1:0]         wdata
);

  localparam int unsigned RW = $clog2(NREG);

  logic [XLEN-1:0] rf_q [NREG];

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign rf_q[gi] = '0;
      end else begin : g_word
        logic [XLEN-1:0] word_reg;
        // Clear on reset; load when this entry is the write target
        always_ff @(posedge clk_i) begin
          if (rst_i) begin
            word_reg <= '0;
          end else if (we && waddr == RW'(gi)) begin
            word_reg <= wdata;
          end
        end
        assign rf_q[gi] = word_reg;
      end
    end
  endgenerate

  assign rdata1   = rf_q[raddr1];
  assign rdata2   = rf_q[raddr2];
  assign dbg_data = rf_q[dbg_addr];

endmodule

// File: rtl/multicycle_cpu.sv
// Multi-cycle RV32-subset core: FETCH/DECODE/EXEC/WB sequenced by one FSM over
// a shared ALU. Instruction fetch uses a req/valid handshake with wait states.
// Define MULTICYCLE_CPU_BRANCH_EN to add BEQ/BNE; otherwise opcode 1100011 halts.
module multicycle_cpu
  import multicycle_cpu_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     NREG     = 32,
  parameter logic [XLEN-1:0] PC_RESET = '0,
  parameter int unsigned     RET_W    = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  output logic                    imem_req_o,
  output logic [XLEN-1:0]         imem_addr_o,
  input  logic [31:0]             imem_rdata_i,
  input  logic                    imem_valid_i,
  input  logic [$clog2(NREG)-1:0] dbg_addr_i,
  output logic [XLEN-1:0]         dbg_data_o,
  output logic [XLEN-1:0]         pc_o,
  output logic [RET_W-1:0]        retired_o,
  output logic                    busy_o,
  output logic                    illegal_o
);

  localparam int unsigned RW  = $clog2(NREG);
  localparam int unsigned SHW = $clog2(XLEN);

  state_e state_reg, state_next;

  logic [XLEN-1:0]  pc_reg;
  logic [31:0]      ir_reg;
  logic [XLEN-1:0]  op_a_reg;
  logic [XLEN-1:0]  op_b_reg;
  logic [XLEN-1:0]  result_reg;
  alu_op_e          alu_op_reg;
  logic             wen_reg;
  logic [RET_W-1:0] retired_reg;
  logic             illegal_reg;
`ifdef MULTICYCLE_CPU_BRANCH_EN
  logic             branch_reg;
  logic             taken_reg;
  logic [XLEN-1:0]  b_imm;
`endif

  logic [XLEN-1:0] rf_rd1, rf_rd2;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] alu_result;
  logic            rf_we;
  dec_t            dec;
  logic            dec_ok;

  // A register field is only addressable if its bits above log2(NREG) are zero
  function automatic logic field_ok(input logic [4:0] f);
    return (f >> RW) == 5'd0;
  endfunction

  assign dec   = decode_op(ir_reg[6:0], ir_reg[14:12], ir_reg[31:25]);
  assign imm_i = {{(XLEN-12){ir_reg[31]}}, ir_reg[31:20]};
  // rs2 field carries immediate bits for I-type, rd field carries offset bits for branches
  assign dec_ok = dec.legal
               && field_ok(ir_reg[19:15])
               && (dec.use_imm || field_ok(ir_reg[24:20]))
               && (!dec.wen || field_ok(ir_reg[11:7]));

`ifdef MULTICYCLE_CPU_BRANCH_EN
  assign b_imm = {{(XLEN-12){ir_reg[31]}}, ir_reg[7], ir_reg[30:25], ir_reg[11:8], 1'b0};
`endif

  assign rf_we = (state_reg == WB) && wen_reg;

  mc_regfile #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_regfile (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .raddr1   (ir_reg[15 +: RW]),
    .raddr2   (ir_reg[20 +: RW]),
    .rdata1   (rf_rd1),
    .rdata2   (rf_rd2),
    .dbg_addr (dbg_addr_i),
    .dbg_data (dbg_data_o),
    .we       (rf_we),
    .waddr    (ir_reg[7 +: RW]),
    .wdata    (result_reg)
  );

  // Shared ALU over the latched operands
  always_comb begin
    alu_result = '0;
    case (alu_op_reg)
      ALU_ADD: alu_result = op_a_reg + op_b_reg;
      ALU_SUB: alu_result = op_a_reg - op_b_reg;
      ALU_AND: alu_result = op_a_reg & op_b_reg;
      ALU_OR:  alu_result = op_a_reg | op_b_reg;
      ALU_XOR: alu_result = op_a_reg ^ op_b_reg;
      ALU_SLL: alu_result = op_a_reg << op_b_reg[SHW-1:0];
      ALU_SRL: alu_result = op_a_reg >> op_b_reg[SHW-1:0];
      ALU_SLT: alu_result = {{(XLEN-1){1'b0}}, ($signed(op_a_reg) < $signed(op_b_reg))};
      default: alu_result = '0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state and handshake/status outputs
  always_comb begin
    state_next = state_reg;
    imem_req_o = 1'b0;
    busy_o     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_i) state_next = FETCH;
      end
      FETCH: begin
        imem_req_o = 1'b1;
        busy_o     = 1'b1;
        if (imem_valid_i) state_next = DECODE;
      end
      DECODE: begin
        busy_o     = 1'b1;
        state_next = dec_ok ? EXEC : HALT;
      end
      EXEC: begin
        busy_o     = 1'b1;
        state_next = WB;
      end
      WB: begin
        busy_o     = 1'b1;
        state_next = start_i ? FETCH : IDLE;
      end
      HALT: begin
        state_next = HALT;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath latches, PC, retire counter and sticky illegal flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_reg      <= PC_RESET;
      ir_reg      <= '0;
      op_a_reg    <= '0;
      op_b_reg    <= '0;
      result_reg  <= '0;
      alu_op_reg  <= ALU_ADD;
      wen_reg     <= 1'b0;
      retired_reg <= '0;
      illegal_reg <= 1'b0;
`ifdef MULTICYCLE_CPU_BRANCH_EN
      branch_reg  <= 1'b0;
      taken_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        FETCH: begin
          if (imem_valid_i) ir_reg <= imem_rdata_i;
        end
        DECODE: begin
          op_a_reg   <= rf_rd1;
          op_b_reg   <= dec.use_imm ? imm_i : rf_rd2;
          alu_op_reg <= dec.op;
          wen_reg    <= dec.wen;
`ifdef MULTICYCLE_CPU_BRANCH_EN
          branch_reg <= dec.branch;
`endif
          if (!dec_ok) illegal_reg <= 1'b1;
        end
        EXEC: begin
          result_reg <= alu_result;
`ifdef MULTICYCLE_CPU_BRANCH_EN
          // funct3[0] distinguishes BNE from BEQ
          taken_reg  <= branch_reg && (ir_reg[12] ? (alu_result != '0) : (alu_result == '0));
`endif
        end
        WB: begin
`ifdef MULTICYCLE_CPU_BRANCH_EN
          pc_reg <= pc_reg + (taken_reg ? b_imm : XLEN'(4));
`else
          pc_reg <= pc_reg + XLEN'(4);
`endif
          retired_reg <= retired_reg + RET_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign pc_o        = pc_reg;
  assign imem_addr_o = pc_reg;
  assign retired_o   = retired_reg;
  assign illegal_o   = illegal_reg;

endmodule
